axi4_rd_arbiter: RTL and testbench

- Shares the single DUT AXI4 master read channel (address and data) between two on-chip read requesters.
- Typical pairing: requester 0 is the TFT LCD frame fetcher, requester 1 is a general DMA or command engine.
- Sits in dut_top between the requesters and the M_AR*/M_R* pins.
- Issues one burst at a time, routes read data back to the granted requester, and checks burst length and ID consistency.

---
 rtl/axi4_rd_arb_pkg.sv | 19 +
 rtl/rr_arbiter_2.sv | 20 ++
 rtl/axi4_rd_arbiter.sv | 146 ++++++++++++++
 tb/tb_axi4_rd_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_rd_arb_pkg.sv
// Shared types and AXI constants for the two-requester AXI4 read arbiter.
package axi4_rd_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } arb_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // AxSIZE encoding for a full-width beat of the given data bus width.
  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way combinational arbiter: round-robin on ties, or fixed priority to requester 0.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the requester that was not served last wins.
      2'b11:   grant = (fixed_prio || last_grant) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Shares one AXI4 master read channel between two requesters, one burst at a time,
// with burst-length and ID consistency checking.
module axi4_rd_arbiter
  import axi4_rd_arb_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = 32,
  parameter int unsigned C_DATA_WIDTH = 128,
  parameter int unsigned C_FIXED_PRIO = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [1:0]                REQ_ARVALID,
  output logic [1:0]                REQ_ARREADY,
  input  logic [2*C_ADDR_WIDTH-1:0] REQ_ARADDR,
  input  logic [15:0]               REQ_ARLEN,
  output logic [1:0]                REQ_RVALID,
  input  logic [1:0]                REQ_RREADY,
  output logic [C_DATA_WIDTH-1:0]   REQ_RDATA,
  output logic [1:0]                REQ_RRESP,
  output logic                      REQ_RLAST,
  output logic                      M_ARID,
  output logic [C_ADDR_WIDTH-1:0]   M_ARADDR,
  output logic [7:0]                M_ARLEN,
  output logic [2:0]                M_ARSIZE,
  output logic [1:0]                M_ARBURST,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  input  logic                      M_RID,
  input  logic [C_DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]                M_RRESP,
  input  logic                      M_RLAST,
  input  logic                      M_RVALID,
  output logic                      M_RREADY,
  output logic                      BUSY,
  output logic                      ERR,
  input  logic                      ERR_CLR
);

  localparam logic FixedPrio = (C_FIXED_PRIO != 0);

  arb_state_e              state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic                    arid_q, arid_d;
  logic [8:0]              beat_cnt_q, beat_cnt_d;
  logic                    last_grant_q, last_grant_d;
  logic                    err_q, err_d;
  logic                    err_set;
  logic [1:0]              grant;
  logic                    at_len;

  rr_arbiter_2 u_arb (
    .req        (REQ_ARVALID),
    .last_grant (last_grant_q),
    .fixed_prio (FixedPrio),
    .grant      (grant)
  );

  assign at_len = (beat_cnt_q == {1'b0, arlen_q});

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arid_d       = arid_q;
    beat_cnt_d   = beat_cnt_q;
    last_grant_d = last_grant_q;
    err_set      = 1'b0;
    REQ_ARREADY  = 2'b00;
    REQ_RVALID   = 2'b00;
    M_ARVALID    = 1'b0;
    M_RREADY     = 1'b0;

    case (state_q)
      StIdle: begin
        if (|REQ_ARVALID) begin
          REQ_ARREADY = grant;
          araddr_d    = grant[1] ? REQ_ARADDR[C_ADDR_WIDTH +: C_ADDR_WIDTH]
                                 : REQ_ARADDR[0 +: C_ADDR_WIDTH];
          arlen_d     = grant[1] ? REQ_ARLEN[15:8] : REQ_ARLEN[7:0];
          arid_d      = grant[1];
          state_d     = StAddr;
        end
      end
      StAddr: begin
        M_ARVALID = 1'b1;
        if (M_ARREADY) begin
          beat_cnt_d = '0;
          state_d    = StData;
        end
      end
      StData: begin
        M_RREADY           = REQ_RREADY[arid_q];
        REQ_RVALID[arid_q] = M_RVALID;
        if (M_RVALID && REQ_RREADY[arid_q]) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (M_RID != arid_q) err_set = 1'b1;
          if (M_RLAST) begin
            if (!at_len) err_set = 1'b1;
            last_grant_d = arid_q;
            state_d      = StIdle;
          end else if (at_len) begin
            // Slave overran the requested length; keep draining until it signals RLAST.
            err_set = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A fresh error outranks a simultaneous clear.
    err_d = err_set | (err_q & ~ERR_CLR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arid_q       <= 1'b0;
      beat_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arid_q       <= arid_d;
      beat_cnt_q   <= beat_cnt_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign M_ARID    = arid_q;
  assign M_ARADDR  = araddr_q;
  assign M_ARLEN   = arlen_q;
  assign M_ARSIZE  = axi_size(C_DATA_WIDTH);
  assign M_ARBURST = BURST_INCR;
  assign REQ_RDATA = M_RDATA;
  assign REQ_RRESP = M_RRESP;
  assign REQ_RLAST = M_RLAST;
  assign BUSY      = (state_q != StIdle);
  assign ERR       = err_q;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed self-checking bench for axi4_rd_arbiter: round-robin instance driven by tasks,
// plus a free-running fixed-priority instance.
module tb_axi4_rd_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      req_arvalid, req_arready, req_rvalid, req_rready, req_rresp, m_rresp, m_arburst;
  logic [2*AW-1:0] req_araddr;
  logic [15:0]     req_arlen;
  logic [DW-1:0]   req_rdata, m_rdata;
  logic            req_rlast, m_arid, m_arvalid, m_arready, m_rid, m_rlast, m_rvalid, m_rready;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic            busy, err, err_clr;

  axi4_rd_arbiter #(
    .C_ADDR_WIDTH (AW),
    .C_DATA_WIDTH (DW),
    .C_FIXED_PRIO (0)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .REQ_ARVALID (req_arvalid),
    .REQ_ARREADY (req_arready),
    .REQ_ARADDR  (req_araddr),
    .REQ_ARLEN   (req_arlen),
    .REQ_RVALID  (req_rvalid),
    .REQ_RREADY  (req_rready),
    .REQ_RDATA   (req_rdata),
    .REQ_RRESP   (req_rresp),
    .REQ_RLAST   (req_rlast),
    .M_ARID      (m_arid),
    .M_ARADDR    (m_araddr),
    .M_ARLEN     (m_arlen),
    .M_ARSIZE    (m_arsize),
    .M_ARBURST   (m_arburst),
    .M_ARVALID   (m_arvalid),
    .M_ARREADY   (m_arready),
    .M_RID       (m_rid),
    .M_RDATA     (m_rdata),
    .M_RRESP     (m_rresp),
    .M_RLAST     (m_rlast),
    .M_RVALID    (m_rvalid),
    .M_RREADY    (m_rready),
    .BUSY        (busy),
    .ERR         (err),
    .ERR_CLR     (err_clr)
  );

  // Fixed-priority instance: both requesters always valid, slave always answers one-beat bursts.
  logic          fp_rst = 1'b1;
  logic [1:0]    fp_req_arready, fp_req_rvalid, fp_req_rresp, fp_m_arburst;
  logic [127:0]  fp_req_rdata;
  logic          fp_req_rlast, fp_m_arid, fp_m_arvalid, fp_m_rready, fp_busy, fp_err;
  logic [AW-1:0] fp_m_araddr;
  logic [7:0]    fp_m_arlen;
  logic [2:0]    fp_m_arsize;
  int            fp_grant0_cnt = 0;
  int            fp_grant1_cnt = 0;

  axi4_rd_arbiter #(
    .C_ADDR_WIDTH (AW),
    .C_DATA_WIDTH (128),
    .C_FIXED_PRIO (1)
  ) dut_fp (
    .CLK         (clk),
    .RST         (fp_rst),
    .REQ_ARVALID (2'b11),
    .REQ_ARREADY (fp_req_arready),
    .REQ_ARADDR  ({32'h0000_9000, 32'h0000_8000}),
    .REQ_ARLEN   (16'h0000),
    .REQ_RVALID  (fp_req_rvalid),
    .REQ_RREADY  (2'b11),
    .REQ_RDATA   (fp_req_rdata),
    .REQ_RRESP   (fp_req_rresp),
    .REQ_RLAST   (fp_req_rlast),
    .M_ARID      (fp_m_arid),
    .M_ARADDR    (fp_m_araddr),
    .M_ARLEN     (fp_m_arlen),
    .M_ARSIZE    (fp_m_arsize),
    .M_ARBURST   (fp_m_arburst),
    .M_ARVALID   (fp_m_arvalid),
    .M_ARREADY   (1'b1),
    .M_RID       (fp_m_arid),
    .M_RDATA     (128'h0),
    .M_RRESP     (2'b00),
    .M_RLAST     (1'b1),
    .M_RVALID    (1'b1),
    .M_RREADY    (fp_m_rready),
    .BUSY        (fp_busy),
    .ERR         (fp_err),
    .ERR_CLR     (1'b0)
  );

  initial begin
    repeat (3) @(posedge clk);
    #1 fp_rst = 1'b0;
  end

  always @(negedge clk) begin
    if (!fp_rst) begin
      if (fp_req_arready[0]) fp_grant0_cnt++;
      if (fp_req_arready[1]) fp_grant1_cnt++;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    req_arvalid = 2'b00;
    req_araddr  = '0;
    req_arlen   = '0;
    req_rready  = 2'b00;
    m_arready   = 1'b0;
    m_rid       = 1'b0;
    m_rdata     = '0;
    m_rresp     = 2'b00;
    m_rlast     = 1'b0;
    m_rvalid    = 1'b0;
    err_clr     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present a request, check the grant, then check the registered AR payload in ADDR.
  task automatic grant_burst(input logic [1:0] valid, input int g, input logic [AW-1:0] addr,
                             input logic [7:0] len);
    req_araddr[g*AW +: AW] = addr;
    req_arlen[g*8 +: 8]    = len;
    req_arvalid            = valid;
    settle();
    check_eq("arready_grant", req_arready, 64'd1 << g);
    tick();
    req_arvalid = 2'b00;
    check_eq("arvalid", m_arvalid, 1);
    check_eq("arid", m_arid, g);
    check_eq("araddr", m_araddr, addr);
    check_eq("arlen", m_arlen, len);
  endtask

  // One accepted data beat; expects it routed to requester g only.
  task automatic beat(input logic rid, input logic [DW-1:0] data, input logic last, input int g);
    m_rvalid = 1'b1;
    m_rid    = rid;
    m_rdata  = data;
    m_rlast  = last;
    settle();
    check_eq("rvalid_route", req_rvalid, 64'd1 << g);
    check_eq("rdata", req_rdata, data);
    check_eq("rlast", req_rlast, last);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  int idx, route_bad, data_bad;
  logic tog, hs;

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_arvalid", m_arvalid, 0);
    check_eq("rst_rready", m_rready, 0);
    check_eq("rst_arready", req_arready, 0);
    check_eq("rst_rvalid", req_rvalid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_araddr", m_araddr, 0);
    check_eq("rst_arlen", m_arlen, 0);
    check_eq("rst_arid", m_arid, 0);
    check_eq("arsize", m_arsize, 2);
    check_eq("arburst", m_arburst, 1);

    // Single request, 4 beats
    req_rready = 2'b11;
    m_arready  = 1'b1;
    grant_burst(2'b01, 0, 32'h0000_1000, 8'd3);
    check_eq("single_busy", busy, 1);
    tick();
    for (int i = 0; i < 4; i++) beat(1'b0, 32'hA0 + i, (i == 3), 0);
    check_eq("single_busy_end", busy, 0);
    check_eq("single_err", err, 0);
    check_eq("single_rvalid_end", req_rvalid, 0);

    // Round-robin with both requesting continuously
    do_reset();
    req_rready  = 2'b11;
    m_arready   = 1'b1;
    req_araddr  = {32'h0000_3000, 32'h0000_2000};
    req_arlen   = 16'h0000;
    req_arvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      settle();
      check_eq("rr_bubble_busy", busy, 0);
      check_eq("rr_grant", req_arready, 64'd1 << (k % 2));
      tick();
      check_eq("rr_arid", m_arid, k % 2);
      tick();
      beat(1'(k % 2), 32'h100 + k, 1'b1, k % 2);
    end
    req_arvalid = 2'b00;

    // Backpressure: AR stalled 5 cycles, RREADY[1] toggling, 256-beat burst
    do_reset();
    grant_burst(2'b10, 1, 32'h0000_4000, 8'd255);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_arvalid_hold", m_arvalid, 1);
      check_eq("bp_araddr_hold", m_araddr, 32'h0000_4000);
      check_eq("bp_arlen_hold", m_arlen, 255);
      tick();
    end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    idx = 0;
    route_bad = 0;
    data_bad = 0;
    tog = 1'b0;
    for (int c = 0; c < 2000 && idx < 256; c++) begin
      m_rvalid   = 1'b1;
      m_rid      = 1'b1;
      m_rdata    = idx;
      m_rlast    = (idx == 255);
      req_rready = {tog, 1'b0};
      settle();
      if (req_rvalid !== 2'b10) route_bad++;
      if (m_rready !== tog) route_bad++;
      hs = tog;
      if (hs && req_rdata !== DW'(idx)) data_bad++;
      tick();
      if (hs) idx++;
      tog = ~tog;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    check_eq("bp_beats", idx, 256);
    check_eq("bp_route_bad", route_bad, 0);
    check_eq("bp_data_bad", data_bad, 0);
    check_eq("bp_busy_end", busy, 0);
    check_eq("bp_err", err, 0);

    // Early RLAST on the third beat of a 4-beat burst
    do_reset();
    req_rready = 2'b11;
    m_arready  = 1'b1;
    grant_burst(2'b01, 0, 32'h0000_5000, 8'd3);
    tick();
    beat(1'b0, 32'h1, 1'b0, 0);
    beat(1'b0, 32'h2, 1'b0, 0);
    beat(1'b0, 32'h3, 1'b1, 0);
    check_eq("err_early_last", err, 1);
    check_eq("err_early_idle", busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("err_clr1", err, 0);

    // Slave overruns length: error but stays in DATA until RLAST
    grant_burst(2'b01, 0, 32'h0000_5100, 8'd1);
    tick();
    beat(1'b0, 32'h11, 1'b0, 0);
    check_eq("err_overrun_pre", err, 0);
    beat(1'b0, 32'h12, 1'b0, 0);
    check_eq("err_overrun", err, 1);
    check_eq("err_overrun_stay", busy, 1);
    beat(1'b0, 32'h13, 1'b1, 0);
    check_eq("err_overrun_idle", busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("err_clr2", err, 0);

    // RID mismatch in the same cycle as ERR_CLR: data still forwarded, error wins
    grant_burst(2'b01, 0, 32'h0000_5200, 8'd0);
    tick();
    err_clr = 1'b1;
    beat(1'b1, 32'h21, 1'b1, 0);
    err_clr = 1'b0;
    check_eq("err_rid_wins_clr", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("err_clr3", err, 0);

    // Reset in the middle of an 8-beat burst
    do_reset();
    req_rready = 2'b11;
    m_arready  = 1'b1;
    grant_burst(2'b10, 1, 32'h0000_6000, 8'd7);
    tick();
    beat(1'b1, 32'h31, 1'b0, 1);
    beat(1'b1, 32'h32, 1'b0, 1);
    m_rvalid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_arvalid", m_arvalid, 0);
    check_eq("mrst_rready", m_rready, 0);
    check_eq("mrst_rvalid", req_rvalid, 0);
    check_eq("mrst_araddr", m_araddr, 0);
    check_eq("mrst_arlen", m_arlen, 0);
    check_eq("mrst_arid", m_arid, 0);
    check_eq("mrst_err", err, 0);
    m_rvalid    = 1'b0;
    req_arvalid = 2'b11;
    settle();
    check_eq("mrst_tie_grant", req_arready, 2'b01);
    req_arvalid = 2'b10;
    settle();
    check_eq("mrst_req1_grant", req_arready, 2'b10);
    req_arvalid = 2'b00;

    // Fixed-priority instance has been running throughout
    check_eq("fp_bursts_ge8", (fp_grant0_cnt >= 8), 1);
    check_eq("fp_req1_never", fp_grant1_cnt, 0);
    check_eq("fp_arsize", fp_m_arsize, 4);
    check_eq("fp_err", fp_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
